// File: rtl/led_seq_pkg.sv
// Shared state encoding and next-state helper for the LED colour sequencer.
package led_seq_pkg;

  typedef logic [1:0] led_state_t;

  localparam led_state_t IDLE  = 2'b00;
  localparam led_state_t RED   = 2'b01;
  localparam led_state_t GREEN = 2'b10;
  localparam led_state_t BLUE  = 2'b11;

  // Colour that follows the given state on one step; BLUE loops back to RED
  function automatic led_state_t seq_next(input led_state_t cur);
    led_state_t nxt;
    case (cur)
      IDLE:    nxt = RED;
      RED:     nxt = GREEN;
      GREEN:   nxt = BLUE;
      BLUE:    nxt = RED;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button.
// Provides the debounced level and a one-cycle pulse on each press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_q;
  logic [CW-1:0] r_cnt;

  // Sample, count disagreement with the stable level, flip once it persists
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_q <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_q <= r_stable;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_stable & ~r_stable_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// Button-driven RGB LED sequencer: IDLE -> RED -> GREEN -> BLUE -> RED.
// Optional timed auto-advance is compiled in with LED_SEQ_AUTO_ADVANCE_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int AUTO_PERIOD     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_button0,
  input  logic             push_button1,
  output logic             led_red,
  output logic             led_green,
  output logic             led_blue,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] adv_count
);

  if ((DEBOUNCE_CYCLES < 2) || (AUTO_PERIOD < 2)) begin : g_bad_param
    $error("led_seq_ctrl: DEBOUNCE_CYCLES and AUTO_PERIOD must be at least 2");
  end

  logic w_stable0;
  logic w_step_p;
  logic w_stable1;
  logic w_restart_p;
  logic w_restart;
  logic w_step;

  led_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_led_red;
  logic             r_led_green;
  logic             r_led_blue;
  led_state_t       w_next_state;
  logic [CNT_W-1:0] w_next_count;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (push_button0),
    .o_stable (w_stable0),
    .o_rise   (w_step_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_restart (
    .clk      (clk),
    .rst      (rst),
    .i_btn    (push_button1),
    .o_stable (w_stable1),
    .o_rise   (w_restart_p)
  );

  // The restart button acts as a level hold; its press pulse is implied by it
  assign w_restart = w_stable1 | w_restart_p;

`ifdef LED_SEQ_AUTO_ADVANCE_EN
  localparam int TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AUTO_PERIOD - 1);

  logic [TW-1:0] r_timer;
  logic          w_auto_step;

  assign w_auto_step = (r_timer == TIMER_LAST) && (r_state != IDLE) && !w_restart;
  assign w_step      = w_step_p | w_auto_step;

  // Idle-time counter; any step (manual or automatic), restart or IDLE clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_restart || (r_state == IDLE) || w_step) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end
`else
  assign w_step = w_step_p;
`endif

  // Next state and counter: restart hold beats any step
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    if (w_restart) begin
      w_next_state = IDLE;
      w_next_count = '0;
    end else if (w_step) begin
      w_next_state = seq_next(r_state);
      w_next_count = r_count + CNT_W'(1);
    end else begin
      w_next_state = r_state;
      w_next_count = r_count;
    end
  end

  // LEDs are registered alongside the state so they change on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_led_red   <= 1'b0;
      r_led_green <= 1'b0;
      r_led_blue  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_count     <= w_next_count;
      r_led_red   <= (w_next_state == RED);
      r_led_green <= (w_next_state == GREEN);
      r_led_blue  <= (w_next_state == BLUE);
    end
  end

  assign led_red   = r_led_red;
  assign led_green = r_led_green;
  assign led_blue  = r_led_blue;
  assign state_o   = r_state;
  assign adv_count = r_count;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with DEBOUNCE_CYCLES=4, CNT_W=3, AUTO_PERIOD=10.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       pb0;
  logic       pb1;
  logic       led_red;
  logic       led_green;
  logic       led_blue;
  logic [1:0] state_o;
  logic [2:0] adv_count;

  int n_checks = 0;
  int n_errors = 0;

  led_seq_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .AUTO_PERIOD(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_button0 (pb0),
    .push_button1 (pb1),
    .led_red      (led_red),
    .led_green    (led_green),
    .led_blue     (led_blue),
    .state_o      (state_o),
    .adv_count    (adv_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // state, one-hot LEDs {blue,green,red} and counter in one go
  task automatic check_all(input string tag, input logic [1:0] st, input logic [2:0] cnt);
    logic [2:0] leds;
    case (st)
      2'b01:   leds = 3'b001;
      2'b10:   leds = 3'b010;
      2'b11:   leds = 3'b100;
      default: leds = 3'b000;
    endcase
    check({tag, "_state"}, 32'(state_o), 32'(st));
    check({tag, "_leds"}, 32'({led_blue, led_green, led_red}), 32'(leds));
    check({tag, "_count"}, 32'(adv_count), 32'(cnt));
  endtask

  task automatic press(input int hold);
    pb0 = 1'b1;
    repeat (hold) tick();
    pb0 = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    logic [1:0] seq_exp [5];
    seq_exp[0] = 2'b01; seq_exp[1] = 2'b10; seq_exp[2] = 2'b11;
    seq_exp[3] = 2'b01; seq_exp[4] = 2'b10;

    rst = 1'b1; pb0 = 1'b0; pb1 = 1'b0;
    repeat (3) tick();
    check_all("reset", 2'b00, 3'd0);
    rst = 1'b0;
    repeat (2) tick();
    check_all("post_reset", 2'b00, 3'd0);

    // clean press: LED rises exactly on the 7th sampling edge
    pb0 = 1'b1;
    repeat (6) tick();
    check("edge6_leds", 32'({led_blue, led_green, led_red}), 32'd0);
    tick();
    check_all("edge7", 2'b01, 3'd1);
    repeat (3) tick();
    check_all("held", 2'b01, 3'd1);
    pb0 = 1'b0;
    repeat (8) tick();
    check_all("released", 2'b01, 3'd1);

    // 3-high/1-low bouncing never qualifies
    repeat (4) begin
      pb0 = 1'b1;
      repeat (3) tick();
      pb0 = 1'b0;
      tick();
    end
    repeat (6) tick();
    check_all("bounce", 2'b01, 3'd1);
    press(4);
    check_all("hold4", 2'b10, 3'd2);

    // asynchronous clear, checked before the next clock edge
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 2'b00, 3'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      press(10);
      check_all($sformatf("seq%0d", i), seq_exp[i], 3'(i + 1));
    end
    press(10);
    check_all("to_blue", 2'b11, 3'd6);

    // simultaneous step and restart: restart wins
    pb0 = 1'b1; pb1 = 1'b1;
    repeat (10) tick();
    check_all("restart_both", 2'b00, 3'd0);
    pb0 = 1'b0;
    repeat (8) tick();
    pb0 = 1'b1;
    repeat (10) tick();
    check_all("restart_hold", 2'b00, 3'd0);
    pb0 = 1'b0; pb1 = 1'b0;
    repeat (8) tick();
    check_all("restart_release", 2'b00, 3'd0);
    press(10);
    check_all("after_restart", 2'b01, 3'd1);

`ifdef LED_SEQ_AUTO_ADVANCE_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pb0 = 1'b1;
    repeat (7) tick();
    check_all("auto_red", 2'b01, 3'd1);
    repeat (9) tick();
    check_all("auto_before", 2'b01, 3'd1);
    tick();
    check_all("auto_green", 2'b10, 3'd2);
    repeat (10) tick();
    check_all("auto_blue", 2'b11, 3'd3);
    pb0 = 1'b0;
`else
    repeat (100) tick();
    check_all("no_auto", 2'b01, 3'd1);
    // seven more steps from count 1 wrap the 3-bit counter to 0
    repeat (7) press(10);
    check_all("wrap", 2'b10, 3'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
